// File: rtl/serial_match_sched_pkg.sv
// ----------------------------------------------------------------------------
// serial_match_sched_pkg
// Shared constants for the serial pattern-match scheduler:
//   - FSM state encodings (IDLE / SHIFT / REPORT)
//   - default pattern and pattern length
// No ports; imported by the interface, the matcher and the scheduler top.
// ----------------------------------------------------------------------------
package serial_match_sched_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] REPORT = 2'd2;

    localparam int unsigned              DEF_PAT_LEN = 4;
    localparam logic [DEF_PAT_LEN-1:0]   DEF_PAT     = 4'b1101;

endpackage

// File: rtl/serial_match_sched_if.sv
// ----------------------------------------------------------------------------
// serial_match_sched_if
// Bundles the word input handshake, the serial bit stream, the result
// handshake and status of serial_match_sched.
//   master : producer/consumer side (drives in_valid, in_data, clear_hist,
//            out_ready)
//   slave  : scheduler side (drives in_ready, bit_out, bit_valid, out_valid,
//            match_count, match_any, busy)
// ----------------------------------------------------------------------------
interface serial_match_sched_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             clear_hist;
    logic             bit_out;
    logic             bit_valid;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] match_count;
    logic             match_any;
    logic             busy;

    modport master (
        output in_valid, in_data, clear_hist, out_ready,
        input  in_ready, bit_out, bit_valid, out_valid, match_count, match_any, busy
    );

    modport slave (
        input  in_valid, in_data, clear_hist, out_ready,
        output in_ready, bit_out, bit_valid, out_valid, match_count, match_any, busy
    );
endinterface

// File: rtl/serial_match_sched_pattern_window_matcher.sv
// ----------------------------------------------------------------------------
// pattern_window_matcher
// Sliding PAT_LEN-bit history of the serial stream with a fill counter, and
// the compare against PAT.
//   clk, rst    : clock, asynchronous active-high reset
//   shift_en_i  : shift bit_i into the history this cycle
//   bit_i       : serial bit (new bit enters at the LSB)
//   clear_i     : zero history and fill; combined with shift_en_i the bit is
//                 shifted into an already cleared history
//   match_o     : combinational pulse, the updated window equals PAT and is
//                 fully populated
// ----------------------------------------------------------------------------
module pattern_window_matcher
    import serial_match_sched_pkg::*;
#(
    parameter int unsigned          PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0]   PAT     = DEF_PAT
) (
    input  logic clk,
    input  logic rst,
    input  logic shift_en_i,
    input  logic bit_i,
    input  logic clear_i,
    output logic match_o
);

    localparam int unsigned    FW   = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0]  FULL = FW'(PAT_LEN);

    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [FW-1:0]      fill_q, fill_d;

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (shift_en_i) begin
            if (clear_i) begin
                hist_d = {{(PAT_LEN-1){1'b0}}, bit_i};
                fill_d = FW'(1);
            end else begin
                hist_d = {hist_q[PAT_LEN-2:0], bit_i};
                if (fill_q != FULL) begin
                    fill_d = fill_q + 1'b1;
                end
            end
        end else if (clear_i) begin
            hist_d = '0;
            fill_d = '0;
        end
    end

    // Fill gating keeps zero history after reset/clear from matching
    // patterns that contain zeros.
    assign match_o = shift_en_i && (hist_d == PAT) && (fill_d == FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/serial_match_sched.sv
// ----------------------------------------------------------------------------
// serial_match_sched
// Accepts WIDTH-bit words over a valid/ready handshake, serializes them
// MSB-first one bit per clock, counts overlapping occurrences of PAT ending
// inside each word and reports the count over a second valid/ready handshake.
// History carries across words, so matches may span word boundaries.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : serial_match_sched_if.slave
//              in_valid/in_ready/in_data    word input handshake
//              clear_hist                   clear pattern history
//              bit_out/bit_valid            serial stream
//              out_valid/out_ready          result handshake
//              match_count/match_any        per-word result
//              busy                         not idle
// ----------------------------------------------------------------------------
module serial_match_sched
    import serial_match_sched_pkg::*;
#(
    parameter int unsigned          WIDTH   = 8,
    parameter int unsigned          PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0]   PAT     = DEF_PAT,
    parameter int unsigned          CNT_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_match_sched_if.slave  bus
);

    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] word_q,  word_d;
    logic [IW-1:0]    idx_q,   idx_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic shift_en;
    logic bit_cur;
    logic match;

    assign shift_en = (state_q == SHIFT);
    assign bit_cur  = shift_en & word_q[idx_q];

    pattern_window_matcher #(
        .PAT_LEN (PAT_LEN),
        .PAT     (PAT)
    ) u_matcher (
        .clk        (clk),
        .rst        (rst),
        .shift_en_i (shift_en),
        .bit_i      (bit_cur),
        .clear_i    (bus.clear_hist),
        .match_o    (match)
    );

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                // in_ready is high throughout IDLE, so in_valid alone accepts.
                if (bus.in_valid) begin
                    word_d  = bus.in_data;
                    idx_d   = IW'(WIDTH - 1);
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (match && (cnt_q != '1)) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (idx_q == '0) begin
                    state_d = REPORT;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            REPORT: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // All outputs decode from registered state only; no in_valid -> in_ready path.
    assign bus.in_ready    = (state_q == IDLE);
    assign bus.bit_valid   = shift_en;
    assign bus.bit_out     = bit_cur;
    assign bus.out_valid   = (state_q == REPORT);
    assign bus.match_count = cnt_q;
    assign bus.match_any   = |cnt_q;
    assign bus.busy        = (state_q != IDLE);

endmodule
